// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: constants shared by the PC stage and the control decoder.
//   - PCSrc select encodings (110/111 are reserved and behave as sequential)
//   - reset / interrupt / undefined-instruction vector addresses
//   - br_offset(): sign-extended, word-scaled branch displacement on bits [30:0]
package pc_unit_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ  = 3'b000,
        PCSRC_BR   = 3'b001,
        PCSRC_J    = 3'b010,
        PCSRC_JR   = 3'b011,
        PCSRC_IRQ  = 3'b100,
        PCSRC_XADR = 3'b101
    } pcsrc_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;

    // Branch target arithmetic lives on bits [30:0] only, so the offset is
    // produced already truncated to 31 bits.
    function automatic logic [30:0] br_offset(input logic [15:0] imm16);
        return {{13{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: decoder <-> PC stage signal bundle.
//   master (decoder side): drives PCSrc, ALUOut0, Instruction, DataBusA, IRQIn
//                          and observes PC, PCPlus4, ReturnAddr, IRQ, Supervisor
//   slave  (pc_unit side): the mirror image
interface pc_unit_if;
    logic [2:0]  PCSrc;
    logic        ALUOut0;
    logic [31:0] Instruction;
    logic [31:0] DataBusA;
    logic        IRQIn;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] ReturnAddr;
    logic        IRQ;
    logic        Supervisor;

    modport master (
        output PCSrc, ALUOut0, Instruction, DataBusA, IRQIn,
        input  PC, PCPlus4, ReturnAddr, IRQ, Supervisor
    );

    modport slave (
        input  PCSrc, ALUOut0, Instruction, DataBusA, IRQIn,
        output PC, PCPlus4, ReturnAddr, IRQ, Supervisor
    );
endinterface

// File: rtl/pc_unit_irq_latch.sv
// pc_unit_irq_latch: timer interrupt edge detector and pending flag.
//   clk, reset  - clock, async active-low reset
//   irq_in      - level request from the timer
//   clear       - high on the cycle the decoder takes the interrupt (PCSrc=100)
//   supervisor  - current PC[31]; masks the request while in kernel mode
//   irq         - pending & ~supervisor, from registers only
module pc_unit_irq_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic clear,
    input  logic supervisor,
    output logic irq
);
    logic irq_d;
    logic pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_d   <= 1'b0;
            pending <= 1'b0;
        end else begin
            irq_d <= irq_in;
            // A fresh edge beats a same-cycle clear so no request is lost.
            if (irq_in && !irq_d)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

    // Kernel mode only hides the request; pending survives until user mode.
    assign irq = pending & ~supervisor;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-cycle MIPS datapath.
//   clk    - system clock
//   reset  - async active-low reset, PC returns to RESET_PC
//   bus    - pc_unit_if.slave: PCSrc/ALUOut0/Instruction/DataBusA/IRQIn in,
//            PC/PCPlus4/ReturnAddr/IRQ/Supervisor out
// PC[31] is the supervisor bit; all address arithmetic is on bits [30:0] so
// sequential flow, branches and jumps never change privilege.
module pc_unit
    import pc_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        irq;

    assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

    always_comb begin
        pc_next = pc_plus4;
        case (bus.PCSrc)
            PCSRC_BR:
                if (bus.ALUOut0)
                    pc_next = {pc[31], pc_plus4[30:0] + br_offset(bus.Instruction[15:0])};
            PCSRC_J:
                pc_next = {pc[31], pc_plus4[30:28], bus.Instruction[25:0], 2'b00};
            // jr can drop to user mode but never climb into kernel mode.
            PCSRC_JR:
                pc_next = {pc[31] & bus.DataBusA[31], bus.DataBusA[30:2], 2'b00};
            PCSRC_IRQ:  pc_next = ILLOP_PC;
            PCSRC_XADR: pc_next = XADR_PC;
            default:    pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    pc_unit_irq_latch u_irq (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (bus.IRQIn),
        .clear      (bus.PCSrc == PCSRC_IRQ),
        .supervisor (pc[31]),
        .irq        (irq)
    );

    // The interrupted instruction has not executed, so it is the return point.
    assign bus.ReturnAddr = (bus.PCSrc == PCSRC_IRQ) ? pc : pc_plus4;
    assign bus.PC         = pc;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.Supervisor = pc[31];
    assign bus.IRQ        = irq;

    // Opcode/funct bits and the word-offset bits of rs are not needed here.
    logic unused;
    assign unused = &{1'b0, bus.Instruction[31:26], bus.DataBusA[1:0]};

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against an arithmetic reference model.
module tb_pc_unit;
    localparam longint M = 64'h8000_0000;  // 2^31: modulus of the low 31 bits

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    // Reference state
    logic [31:0] m_pc  = 32'h8000_0000;
    bit          m_irqd = 1'b0;
    bit          m_pend = 1'b0;

    pc_unit_if bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seq_of(input logic [31:0] p);
        longint r;
        r = (longint'(p[30:0]) + 4) % M;
        return {p[31], r[30:0]};
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [2:0] src,
                                               input logic alu, input logic [31:0] ins,
                                               input logic [31:0] a);
        longint p4, off, r;
        logic   top;
        top = p[31];
        p4  = (longint'(p[30:0]) + 4) % M;
        r   = p4;
        case (src)
            3'd1: if (alu) begin
                off = longint'($signed(ins[15:0])) * 4;
                r   = ((p4 + off) % M + M) % M;
            end
            3'd2: r = (p4 / 268435456) * 268435456 + longint'(ins[25:0]) * 4;
            3'd3: begin
                top = p[31] & a[31];
                r   = (longint'(a[30:0]) / 4) * 4;
            end
            3'd4: return 32'h8000_0004;
            3'd5: return 32'h8000_0008;
            default: r = p4;
        endcase
        return {top, r[30:0]};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en && reset) begin
            logic [31:0] e_p4;
            e_p4 = seq_of(m_pc);
            chk("PC", bus.PC, m_pc);
            chk("PCPlus4", bus.PCPlus4, e_p4);
            chk("ReturnAddr", bus.ReturnAddr, (bus.PCSrc == 3'd4) ? m_pc : e_p4);
            chk("IRQ", {31'd0, bus.IRQ}, {31'd0, m_pend & ~m_pc[31]});
            chk("Supervisor", {31'd0, bus.Supervisor}, {31'd0, m_pc[31]});
        end
    end

    task automatic set_in(input logic [2:0] s, input logic alu, input logic [31:0] ins,
                          input logic [31:0] a, input logic irq);
        bus.PCSrc       = s;
        bus.ALUOut0     = alu;
        bus.Instruction = ins;
        bus.DataBusA    = a;
        bus.IRQIn       = irq;
    endtask

    // One rising edge; model advances from the inputs held across it.
    task automatic adv();
        logic [31:0] nxt;
        bit rise;
        @(posedge clk);
        if (reset) begin
            nxt    = model_next(m_pc, bus.PCSrc, bus.ALUOut0, bus.Instruction, bus.DataBusA);
            rise   = bus.IRQIn && !m_irqd;
            m_pend = rise ? 1'b1 : ((bus.PCSrc == 3'd4) ? 1'b0 : m_pend);
            m_irqd = bus.IRQIn;
            m_pc   = nxt;
        end
        #1;
    endtask

    task automatic model_reset();
        m_pc   = 32'h8000_0000;
        m_irqd = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic step(input logic [2:0] s, input logic alu, input logic [31:0] ins,
                        input logic [31:0] a, input logic irq);
        set_in(s, alu, ins, a, irq);
        adv();
    endtask

    initial begin
        set_in(3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_PC", bus.PC, 32'h8000_0000);
        chk("rst_IRQ", {31'd0, bus.IRQ}, 32'd0);
        reset = 1'b1;
        model_reset();
        check_en = 1'b1;
        #1;
        chk("rst_PCPlus4", bus.PCPlus4, 32'h8000_0004);
        chk("rst_RetAddr", bus.ReturnAddr, 32'h8000_0004);
        chk("rst_Super", {31'd0, bus.Supervisor}, 32'd1);
        step(3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("seq2_PC", bus.PC, 32'h8000_0008);

        // jr from kernel drops to user
        step(3'd3, 1'b0, 32'h0, 32'h0000_2000, 1'b0);
        chk("jrk_PC", bus.PC, 32'h0000_2000);
        chk("jrk_Super", {31'd0, bus.Supervisor}, 32'd0);

        // Backward branch by one word
        step(3'd3, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
        step(3'd1, 1'b1, 32'h1000_FFFF, 32'h0, 1'b0);
        chk("br_taken", bus.PC, 32'h0000_0100);
        step(3'd1, 1'b0, 32'h1000_FFFF, 32'h0, 1'b0);
        chk("br_not", bus.PC, 32'h0000_0104);

        // jr from user cannot raise privilege, low bits dropped
        step(3'd3, 1'b0, 32'h0, 32'h0000_0040, 1'b0);
        step(3'd3, 1'b0, 32'h0, 32'h8000_0013, 1'b0);
        chk("jru_PC", bus.PC, 32'h0000_0010);
        chk("jru_Super", {31'd0, bus.Supervisor}, 32'd0);

        // Undefined-instruction exception
        set_in(3'd5, 1'b0, 32'h0, 32'h0, 1'b0);
        #1 chk("xadr_Ret", bus.ReturnAddr, 32'h0000_0014);
        adv();
        chk("xadr_PC", bus.PC, 32'h8000_0008);

        // Reserved select behaves as sequential
        step(3'd6, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rsv_PC", bus.PC, 32'h8000_000C);

        // User-mode interrupt: request rises as jr lands on 0x200
        step(3'd3, 1'b0, 32'h0, 32'h0000_0200, 1'b1);
        chk("irq_PC", bus.PC, 32'h0000_0200);
        chk("irq_on", {31'd0, bus.IRQ}, 32'd1);
        set_in(3'd4, 1'b0, 32'h0, 32'h0, 1'b1);
        #1 chk("irq_Ret", bus.ReturnAddr, 32'h0000_0200);
        adv();
        chk("irq_vec", bus.PC, 32'h8000_0004);
        // Level still high, no new edge: back in user mode IRQ must stay low
        step(3'd3, 1'b0, 32'h0, 32'h0000_0800, 1'b1);
        chk("irq_clr", {31'd0, bus.IRQ}, 32'd0);

        // Masked in kernel, fires on return to user
        step(3'd4, 1'b0, 32'h0, 32'h0, 1'b0);             // back to kernel, IRQIn low
        step(3'd2, 1'b0, 32'h0800_0040, 32'h0, 1'b0);     // j -> 0x8000_0100
        chk("j_PC", bus.PC, 32'h8000_0100);
        step(3'd0, 1'b0, 32'h0, 32'h0, 1'b1);             // pulse in kernel
        chk("mask_IRQ", {31'd0, bus.IRQ}, 32'd0);
        step(3'd3, 1'b0, 32'h0, 32'h0000_0300, 1'b0);
        chk("unmask_PC", bus.PC, 32'h0000_0300);
        chk("unmask_IRQ", {31'd0, bus.IRQ}, 32'd1);

        // New edge coincident with the clear: pending must survive
        step(3'd4, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("coin_mask", {31'd0, bus.IRQ}, 32'd0);
        step(3'd3, 1'b0, 32'h0, 32'h0000_0400, 1'b1);
        chk("coin_IRQ", {31'd0, bus.IRQ}, 32'd1);

        // Reset mid-cycle takes effect immediately
        set_in(3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_PC", bus.PC, 32'h8000_0000);
        chk("arst_IRQ", {31'd0, bus.IRQ}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        step(3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("arst_first", bus.PC, 32'h8000_0004);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic        irq;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31] = 1'b0;
            irq = ($urandom_range(0, 3) == 0) ? ~bus.IRQIn : bus.IRQIn;
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, a, irq);
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle MIPS datapath, directly upstream of the control decoder. It holds the PC and supervisor bit, and computes the next PC from the decoder's 3-bit PCSrc select, the branch condition, the jump/branch fields and the rs register value. It also latches timer interrupt requests and presents a masked, registered IRQ back to the decoder. It supplies the return address that the register file writes for jal, jalr, exceptions and interrupts.

## Interface
- RESET_PC, 32'h8000_0000, PC value after reset (kernel space)
- ILLOP_PC, 32'h8000_0004, interrupt vector
- XADR_PC, 32'h8000_0008, undefined-instruction exception vector
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low (reset=0 clears state immediately)
- PCSrc  in  3  next-PC select from decoder: 000 seq, 001 branch, 010 jump, 011 jr/jalr, 100 IRQ, 101 XADR, 110/111 reserved
- ALUOut0  in  1  branch condition (ALU result bit 0)
- Instruction  in  32  current instruction, supplies imm16 [15:0] and target [25:0]
- DataBusA  in  32  rs register value for jr/jalr
- IRQIn  in  1  level interrupt request from timer peripheral
- PC  out  32  current PC, drives instruction memory
- PCPlus4  out  32  {PC[31], PC[30:0]+4}
- ReturnAddr  out  32  value written to $ra/$26: PC when PCSrc=100, else PCPlus4
- IRQ  out  1  masked interrupt to decoder
- Supervisor  out  1  equals PC[31]

## Operation
- Next-PC, with all additions mod 2^31 on bits [30:0]:
  - 000: PCPlus4.
  - 001: ALUOut0 ? {PC[31], PCPlus4[30:0] + (sext(imm16)<<2)[30:0]} : PCPlus4.
  - 010: {PC[31], PCPlus4[30:28], target, 2'b00}.
  - 011: {PC[31] & DataBusA[31], DataBusA[30:2], 2'b00}. jr never raises privilege; low bits are forced to 0.
  - 100: ILLOP_PC. 101: XADR_PC. 110/111: treated as 000.
- Sequential increments never set or clear bit 31. Wrap from 31'h7FFF_FFFC to 0 keeps the current bit 31.
- IRQ latch:
  - IRQIn is registered as irq_d. A rising edge (IRQIn & ~irq_d) sets pending.
  - pending clears on a clock where PCSrc=100.
  - A simultaneous rising edge and clear leaves pending=1 (the set wins).
  - A level held high without a new edge does not re-set pending.
- IRQ = pending & ~PC[31]. Interrupts are masked in supervisor mode, but pending is retained and fires on return to user mode.

## Timing
- Reset values: PC=RESET_PC, pending=0, irq_d=0, IRQ=0, Supervisor=1, PCPlus4=32'h8000_0004, ReturnAddr=32'h8000_0004 (PCSrc=000).
- PC is updated one rising edge after PCSrc and its operands are valid; the unit is single-cycle with no stall input.
- IRQ is decoded from registers only, with no combinational path from IRQIn. The earliest IRQ=1 is one edge after the IRQIn rising edge.
- ReturnAddr and PCPlus4 are combinational from PC and PCSrc.
- Reset asserted mid-instruction forces the reset values immediately. The first edge after reset deassertion executes from RESET_PC.

## Structure
- Shared package: PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_IRQ, PCSRC_XADR) and the vector addresses. The decoder uses the same constants.
- One sub-module: irq_latch (IRQIn edge detect, pending flag, PC[31] masking). The rest of the block is the PC register and the next-PC mux.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release. PC=32'h8000_0000, IRQ=0; after 2 sequential edges PC=32'h8000_0008.
- Branch, PC=32'h0000_0100, imm16=16'hFFFF:
  - ALUOut0=1 -> PC=32'h0000_0100.
  - ALUOut0=0 -> PC=32'h0000_0104.
- jr from user mode, PC=32'h0000_0040, DataBusA=32'h8000_0013 -> PC=32'h0000_0010, Supervisor=0.
- jr from kernel with DataBusA=32'h0000_2000 -> PC=32'h0000_2000 and Supervisor=0.
- IRQ in user mode: IRQIn rises at PC=32'h0000_0200 -> IRQ=1 next cycle. Drive PCSrc=100 -> ReturnAddr=32'h0000_0200, then PC=32'h8000_0004 and pending=0.
- Masked IRQ: IRQIn pulse while PC=32'h8000_0100 -> IRQ stays 0. After jr to 32'h0000_0300, IRQ=1 in the same cycle PC=32'h0000_0300.
- Boundaries:
  - PCSrc=101 at PC=32'h0000_0010 -> ReturnAddr=32'h0000_0014, PC=32'h8000_0008.
  - PCSrc=110 -> PC advances by 4.
  - Rising edge on IRQIn coincident with PCSrc=100 -> pending remains 1.
